// File: rtl/fifo18k_fwft_reader.sv
// First-word-fall-through adapter for a latency-1 FIFO read port.
// A head register and a skid register let the block run at one word per cycle under backpressure.
module fifo18k_fwft_reader #(
  parameter int DATA_WIDTH = 18
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  output logic                  FIFO_RDEN,
  input  logic                  FLUSH,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [15:0]           WORD_COUNT
);

  typedef enum logic [1:0] {
    OCC_ZERO = 2'd0,
    OCC_ONE  = 2'd1,
    OCC_TWO  = 2'd2
  } occ_t;

  occ_t                  occ;
  occ_t                  occ_next;
  logic                  inflight;
  logic                  pop;
  logic [1:0]            level_next;
  logic [DATA_WIDTH-1:0] skid;

  // Occupancy plus the word already requested never exceeds two, so the
  // 2-bit level cannot underflow (pop implies occ != ZERO).
  always_comb begin
    pop        = M_VALID & M_READY;
    level_next = occ + {1'b0, inflight} - {1'b0, pop};
    occ_next   = occ_t'(level_next);
    FIFO_RDEN  = !RESET && !FLUSH && !FIFO_EMPTY && (level_next < 2'd2);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      occ        <= OCC_ZERO;
      inflight   <= 1'b0;
      M_VALID    <= 1'b0;
      M_DATA     <= '0;
      skid       <= '0;
      WORD_COUNT <= '0;
    end else begin
      if (pop)
        WORD_COUNT <= WORD_COUNT + 16'd1;
      if (FLUSH) begin
        occ      <= OCC_ZERO;
        inflight <= 1'b0;
        M_VALID  <= 1'b0;
      end else begin
        occ      <= occ_next;
        inflight <= FIFO_RDEN;
        M_VALID  <= (occ_next != OCC_ZERO);
        // Returning data goes to skid only when head is occupied and not leaving.
        if (inflight) begin
          if (occ == OCC_ONE && !pop)
            skid <= FIFO_RD_DATA;
          else
            M_DATA <= FIFO_RD_DATA;
        end else if (pop && occ == OCC_TWO) begin
          M_DATA <= skid;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo18k_fwft_reader.sv
// Self-checking bench for fifo18k_fwft_reader: FIFO model, scoreboard of requested words, directed and random scenarios.
module tb_fifo18k_fwft_reader;

  localparam int DW = 18;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] rd_data = '0;
  logic          FIFO_RDEN;
  logic          FLUSH = 1'b0;
  logic [DW-1:0] M_DATA;
  logic          M_VALID;
  logic          M_READY = 1'b0;
  logic [15:0]   WORD_COUNT;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [15:0]   exp_count = '0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  fifo18k_fwft_reader #(.DATA_WIDTH(DW)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .FIFO_EMPTY   (fifo_empty),
    .FIFO_RD_DATA (rd_data),
    .FIFO_RDEN    (FIFO_RDEN),
    .FLUSH        (FLUSH),
    .M_DATA       (M_DATA),
    .M_VALID      (M_VALID),
    .M_READY      (M_READY),
    .WORD_COUNT   (WORD_COUNT)
  );

  initial forever #5 CLK = ~CLK;

  // Behavioural FIFO read side: data valid one clock after the read enable.
  always @(posedge CLK) begin
    if (FIFO_RDEN && fifo_q.size() > 0)
      rd_data <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Scoreboard: every requested word must be delivered in order unless flushed or reset.
  always @(negedge CLK) begin
    if (!RESET) begin
      checks++;
      if (WORD_COUNT !== exp_count) begin
        errors++;
        $display("FAIL word_count: got %0d want %0d at %0t", WORD_COUNT, exp_count, $time);
      end
      checks++;
      if (FIFO_RDEN && fifo_empty) begin
        errors++;
        $display("FAIL underflow: FIFO_RDEN=1 with FIFO_EMPTY=1 at %0t", $time);
      end
      checks++;
      if (exp_q.size() > 2 || (M_VALID && exp_q.size() == 0)) begin
        errors++;
        $display("FAIL occupancy: outstanding=%0d valid=%0b, want <=2 and >0 when valid at %0t",
                 exp_q.size(), M_VALID, $time);
      end
      if (prev_stall) begin
        checks++;
        if (!M_VALID || M_DATA !== prev_data) begin
          errors++;
          $display("FAIL hold: valid=%0b data=%h want valid=1 data=%h at %0t",
                   M_VALID, M_DATA, prev_data, $time);
        end
      end
      prev_stall = M_VALID && !M_READY && !FLUSH;
      prev_data  = M_DATA;
      if (M_VALID && M_READY) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL order: got %h want no word at %0t", M_DATA, $time);
        end else begin
          if (M_DATA !== exp_q[0]) begin
            errors++;
            $display("FAIL order: got %h want %h at %0t", M_DATA, exp_q[0], $time);
          end
          void'(exp_q.pop_front());
        end
        exp_count = exp_count + 16'd1;
      end
      if (FLUSH)
        exp_q.delete();
      else if (FIFO_RDEN && fifo_q.size() > 0)
        exp_q.push_back(fifo_q[0]);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_drain(input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !M_VALID && !FIFO_RDEN) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    exp_q.delete();
    exp_count  = '0;
    prev_stall = 1'b0;
    step();
    step();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] w;
    logic ok;
    step();
    step();
    w = DW'($urandom);
    push(w);
    #1;
    checks++;
    if (FIFO_RDEN !== 1'b0 || M_VALID !== 1'b0 || M_DATA !== '0 || WORD_COUNT !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: rden=%0b valid=%0b data=%h count=%0d want 0 0 0 0",
               FIFO_RDEN, M_VALID, M_DATA, WORD_COUNT);
    end
    step();
    RESET = 1'b0;
    #1;
    checks++;
    if (FIFO_RDEN !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rden: got %0b want 1", FIFO_RDEN);
    end
    step();
    checks++;
    if (M_VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_early: valid=%0b want 0", M_VALID);
    end
    step();
    checks++;
    if (M_VALID !== 1'b1 || M_DATA !== w) begin
      errors++;
      $display("FAIL reset_release_first: valid=%0b data=%h want 1 %h", M_VALID, M_DATA, w);
    end
    M_READY = 1'b1;
    wait_drain(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_drain: timeout got ok=0 want 1");
    end
  endtask

  task automatic test_latency();
    logic [15:0] base;
    logic [DW-1:0] want[3];
    want[0] = 18'h00001;
    want[1] = 18'h00002;
    want[2] = 18'h00003;
    base = exp_count;
    M_READY = 1'b1;
    for (int unsigned i = 0; i < 3; i++) push(want[i]);
    #1;
    checks++;
    if (FIFO_RDEN !== 1'b1) begin
      errors++;
      $display("FAIL latency_rden: got %0b want 1", FIFO_RDEN);
    end
    step();
    checks++;
    if (M_VALID !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: valid=%0b want 0", M_VALID);
    end
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      checks++;
      if (M_VALID !== 1'b1 || M_DATA !== want[i]) begin
        errors++;
        $display("FAIL latency_seq%0d: valid=%0b data=%h want 1 %h", i, M_VALID, M_DATA, want[i]);
      end
    end
    step();
    checks++;
    if (M_VALID !== 1'b0 || WORD_COUNT !== 16'(base + 16'd3)) begin
      errors++;
      $display("FAIL latency_end: valid=%0b count=%0d want 0 %0d", M_VALID, WORD_COUNT, base + 16'd3);
    end
  endtask

  task automatic test_stall();
    logic [15:0] base;
    logic [DW-1:0] w0;
    int pulses;
    logic ok;
    base = exp_count;
    M_READY = 1'b0;
    w0 = DW'($urandom);
    push(w0);
    for (int unsigned i = 1; i < 5; i++) push(DW'($urandom));
    #1;
    pulses = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (FIFO_RDEN) pulses++;
      step();
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL stall_rden_pulses: got %0d want 2", pulses);
    end
    checks++;
    if (M_VALID !== 1'b1 || M_DATA !== w0) begin
      errors++;
      $display("FAIL stall_head: valid=%0b data=%h want 1 %h", M_VALID, M_DATA, w0);
    end
    M_READY = 1'b1;
    wait_drain(40, ok);
    checks++;
    if (!ok || WORD_COUNT !== 16'(base + 16'd5)) begin
      errors++;
      $display("FAIL stall_drain: ok=%0b count=%0d want 1 %0d", ok, WORD_COUNT, base + 16'd5);
    end
  endtask

  task automatic test_toggle();
    logic [15:0] base;
    logic ok;
    base = exp_count;
    for (int unsigned i = 0; i < 20; i++) push(DW'($urandom));
    M_READY = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !M_VALID) begin
        ok = 1'b1;
        break;
      end
      step();
      M_READY = ~M_READY;
    end
    checks++;
    if (!ok || WORD_COUNT !== 16'(base + 16'd20)) begin
      errors++;
      $display("FAIL toggle_drain: ok=%0b count=%0d want 1 %0d", ok, WORD_COUNT, base + 16'd20);
    end
  endtask

  task automatic test_random();
    logic [15:0] base;
    int n;
    logic ok;
    base = exp_count;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        push(DW'($urandom));
        n++;
      end
      M_READY = 1'($urandom_range(0, 1));
      step();
    end
    M_READY = 1'b1;
    wait_drain(600, ok);
    checks++;
    if (!ok || WORD_COUNT !== 16'(base + 16'(n))) begin
      errors++;
      $display("FAIL random_drain: ok=%0b count=%0d want 1 %0d", ok, WORD_COUNT, 16'(base + 16'(n)));
    end
  endtask

  task automatic test_flush();
    logic [15:0] base;
    logic [DW-1:0] w[5];
    logic ok;
    M_READY = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      w[i] = DW'($urandom);
      push(w[i]);
    end
    step();
    step();
    step();
    checks++;
    if (M_VALID !== 1'b1 || M_DATA !== w[0] || FIFO_RDEN !== 1'b0) begin
      errors++;
      $display("FAIL flush_setup: valid=%0b data=%h rden=%0b want 1 %h 0", M_VALID, M_DATA, FIFO_RDEN, w[0]);
    end
    base = exp_count;
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    checks++;
    if (M_VALID !== 1'b0 || M_DATA !== w[0] || WORD_COUNT !== base) begin
      errors++;
      $display("FAIL flush_clear: valid=%0b data=%h count=%0d want 0 %h %0d",
               M_VALID, M_DATA, WORD_COUNT, w[0], base);
    end
    step();
    checks++;
    if (M_VALID !== 1'b0) begin
      errors++;
      $display("FAIL flush_early: valid=%0b want 0", M_VALID);
    end
    step();
    checks++;
    if (M_VALID !== 1'b1 || M_DATA !== w[2]) begin
      errors++;
      $display("FAIL flush_next_word: valid=%0b data=%h want 1 %h", M_VALID, M_DATA, w[2]);
    end
    FLUSH = 1'b1;
    M_READY = 1'b1;
    step();
    FLUSH = 1'b0;
    checks++;
    if (M_VALID !== 1'b0 || WORD_COUNT !== 16'(base + 16'd1)) begin
      errors++;
      $display("FAIL flush_with_pop: valid=%0b count=%0d want 0 %0d", M_VALID, WORD_COUNT, base + 16'd1);
    end
    step();
    step();
    checks++;
    if (M_VALID !== 1'b1 || M_DATA !== w[4]) begin
      errors++;
      $display("FAIL flush_after_pop: valid=%0b data=%h want 1 %h", M_VALID, M_DATA, w[4]);
    end
    wait_drain(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL flush_drain: timeout got ok=0 want 1");
    end
  endtask

  task automatic test_reset_midflight();
    logic [DW-1:0] w[4];
    logic ok;
    M_READY = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      w[i] = DW'($urandom);
      push(w[i]);
    end
    step();
    step();
    checks++;
    if (M_VALID !== 1'b1 || M_DATA !== w[0]) begin
      errors++;
      $display("FAIL midreset_setup: valid=%0b data=%h want 1 %h", M_VALID, M_DATA, w[0]);
    end
    #3;
    RESET = 1'b1;
    exp_q.delete();
    exp_count  = '0;
    prev_stall = 1'b0;
    #1;
    checks++;
    if (M_VALID !== 1'b0 || M_DATA !== '0 || WORD_COUNT !== 16'd0 || FIFO_RDEN !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: valid=%0b data=%h count=%0d rden=%0b want 0 0 0 0",
               M_VALID, M_DATA, WORD_COUNT, FIFO_RDEN);
    end
    step();
    step();
    RESET = 1'b0;
    M_READY = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (M_VALID) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok || M_DATA !== w[2]) begin
      errors++;
      $display("FAIL midreset_next: ok=%0b data=%h want 1 %h", ok, M_DATA, w[2]);
    end
    wait_drain(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midreset_drain: timeout got ok=0 want 1");
    end
  endtask

  task automatic test_wrap();
    int cycles;
    logic ok;
    pulse_reset();
    M_READY = 1'b1;
    for (int unsigned i = 0; i < 65537; i++) push(DW'($urandom));
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 65700; i++) begin
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !M_VALID) begin
        ok = 1'b1;
        break;
      end
      step();
      cycles++;
    end
    checks++;
    if (!ok || WORD_COUNT !== 16'h0001) begin
      errors++;
      $display("FAIL wrap_count: ok=%0b count=%h want 1 0001", ok, WORD_COUNT);
    end
    checks++;
    if (cycles > 65537 + 4) begin
      errors++;
      $display("FAIL throughput: cycles=%0d want <=%0d", cycles, 65537 + 4);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_toggle();
    test_random();
    test_flush();
    test_reset_midflight();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
